writeback_ctrl: RTL and testbench
=================================

Name: writeback_ctrl

Overview:
- Write-side driver for the integer register file: merges results from the single-cycle ALU path and the long-latency load/MDU path into one registered write port (rf_A3/rf_WD3/rf_WE).
- Buffers long-latency results in a small in-order FIFO.
- Keeps a per-register pending (busy) scoreboard so decode can stall on outstanding long-latency destinations.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; power of two, at least 2.
- XLEN, 32, data width.

Ports:
- CLK  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; never back-pressured.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- mem_valid  in  1  long-latency result offered.
- mem_ready  out  1  FIFO can accept; transfer when mem_valid and mem_ready.
- mem_rd  in  5  long-latency destination register.
- mem_data  in  XLEN  long-latency result.
- iss_valid  in  1  long-latency instruction issued this cycle.
- iss_rd  in  5  its destination register.
- busy  out  32  pending-write bit per register; bit 0 is always 0.
- rf_A3  out  5  register file write address.
- rf_WD3  out  XLEN  register file write data.
- rf_WE  out  1  register file write enable.

Behaviour:
- Reset (async): FIFO empty (rd ptr = wr ptr = count = 0); busy = 0; rf_WE = 0, rf_A3 = 0, rf_WD3 = 0; mem_ready = 0 while reset is high. Reset mid-operation discards all FIFO contents and pending bits.
- mem_ready = !reset && count < DEPTH, combinational on count.
- A push at edge N makes the entry selectable in cycle N+1.
- Selection, once per cycle, with fixed priority:
  - alu_valid && alu_rd != 0: ALU selected.
  - Otherwise, FIFO non-empty: head popped and selected.
  - Otherwise: nothing selected.
- ALU results with rd = 0 are treated as not valid; the FIFO may use that slot.
- The selected entry is registered into rf_A3/rf_WD3 with rf_WE = 1 on the next edge. Latency:
  - ALU: 1 cycle.
  - Long-latency: 2 cycles minimum (push edge, then select edge).
- When nothing is selected, rf_WE = 0 and rf_A3/rf_WD3 hold their last values.
- A FIFO head with rd = 0 is popped and produces rf_WE = 0. Its busy bit is not touched.
- Push and pop in the same cycle: count unchanged, allowed when full. mem_ready is still computed from pre-edge count, so a full FIFO deasserts mem_ready.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- FIFO is strictly in order; writes to the same rd from the long-latency path commit in arrival order.
- Scoreboard:
  - iss_valid && iss_rd != 0 sets busy[iss_rd] at the edge.
  - A FIFO pop with rd = r clears busy[r] at the same edge the write is registered.
  - Set and clear of the same bit in one cycle: set wins.
- ALU writes never modify busy. Decode must not issue an ALU op to a register whose busy bit is set (WAW), and must stall reads of busy registers.
- busy[0] is hard-wired to 0.

Optional Feature:
- Macro WB_MEM_BYPASS_EN.
- Defined: when the FIFO is empty, no ALU write is selected, and mem_valid is high, the mem entry is selected directly without a push. Long-latency latency becomes 1 cycle, and busy is cleared at that edge.
- Undefined: every long-latency result passes through the FIFO (2-cycle minimum).
- mem_ready semantics are identical in both builds.

Decomposition:
- Package wb_pkg holds:
  - XLEN = 32, NREG = 32, REG_ZERO = 5'd0.
  - typedef wb_entry_t, a packed struct {rd[4:0], data[XLEN-1:0]}.
- One sub-module: wb_fifo, parameterised DEPTH, carrying wb_entry_t.
  - Ports: push, push_data, pop, head, empty, full, count; same CLK/reset convention.
- writeback_ctrl contains the arbiter, output register and scoreboard.

Test Plan:
- Reset mid-traffic (FIFO holds 3 entries, busy = 0x0000_0106) -> rf_WE = 0, busy = 0 and mem_ready = 0 during reset; mem_ready = 1 and count = 0 after release.
- alu_valid, rd = 5, data = 0xDEAD_BEEF at cycle N -> rf_WE = 1, rf_A3 = 5, rf_WD3 = 0xDEAD_BEEF in cycle N+1 only.
- Issue rd = 7, then push mem rd = 7, data = 0x1234 while the ALU writes rd = 3 for 3 consecutive cycles -> the mem write appears the cycle after the ALU stream ends; busy[7] clears at that edge.
- With the ALU held busy, push DEPTH + 1 entries -> mem_ready drops after 4 accepted; 5th accepted only after the first pop; commits in order with no loss.
- mem push rd = 0, data = 0xFFFF_FFFF; ALU rd = 0 -> no rf_WE for either; FIFO count returns to 0.
- iss_valid rd = 9 in the same cycle the FIFO pops rd = 9 -> busy[9] = 1 afterwards. With WB_MEM_BYPASS_EN, an idle-state mem push rd = 4 -> rf_WE in the next cycle (latency 1).

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback path.
package wb_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result FIFO for the long-latency writeback path; push while full is
// accepted only when a pop happens on the same edge.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_data,
  input  logic                       pop,
  output wb_entry_t                  head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  wb_entry_t     store [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign head    = store[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge CLK) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file write port arbiter (ALU over FIFO head), output register and
// pending-write scoreboard. Optional WB_MEM_BYPASS_EN lets an idle mem result skip the FIFO.
module writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = wb_pkg::XLEN
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic [31:0]     busy,
  output logic [4:0]      rf_A3,
  output logic [XLEN-1:0] rf_WD3,
  output logic            rf_WE
);

  import wb_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  wb_entry_t       fifo_in;
  wb_entry_t       head;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;
  logic            fifo_push;
  logic            fifo_pop;
  logic            alu_sel;
  logic            byp_sel;
  logic            sel_valid;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [NREG-1:0] busy_nxt;

  assign mem_ready = !reset && !fifo_full && (fifo_count < CW'(DEPTH));
  assign alu_sel   = alu_valid && (alu_rd != REG_ZERO);
  assign fifo_pop  = !alu_sel && !fifo_empty;

`ifdef WB_MEM_BYPASS_EN
  assign byp_sel = !alu_sel && fifo_empty && mem_valid && mem_ready;
`else
  assign byp_sel = 1'b0;
`endif

  assign fifo_push    = mem_valid && mem_ready && !byp_sel;
  assign fifo_in.rd   = mem_rd;
  assign fifo_in.data = mem_data;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // A popped or bypassed entry targeting x0 is consumed but never written.
  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = REG_ZERO;
    sel_data  = '0;
    if (alu_sel) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (fifo_pop) begin
      sel_valid = (head.rd != REG_ZERO);
      sel_rd    = head.rd;
      sel_data  = head.data;
    end else if (byp_sel) begin
      sel_valid = (mem_rd != REG_ZERO);
      sel_rd    = mem_rd;
      sel_data  = mem_data;
    end
  end

  // Issue sets win over same-cycle commits so a reissued register stays pending.
  always_comb begin
    busy_nxt = busy;
    if (fifo_pop) busy_nxt[head.rd] = 1'b0;
    if (byp_sel)  busy_nxt[mem_rd]  = 1'b0;
    if (iss_valid && (iss_rd != REG_ZERO)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      rf_WE  <= 1'b0;
      rf_A3  <= REG_ZERO;
      rf_WD3 <= '0;
      busy   <= '0;
    end else begin
      rf_WE <= sel_valid;
      if (sel_valid) begin
        rf_A3  <= sel_rd;
        rf_WD3 <= sel_data;
      end
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed testbench for writeback_ctrl; exercises both builds of WB_MEM_BYPASS_EN.
module tb_writeback_ctrl;

  logic        CLK;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [31:0] busy;
  logic [4:0]  rf_A3;
  logic [31:0] rf_WD3;
  logic        rf_WE;

  int vectors;
  int miscompares;

  writeback_ctrl #(.DEPTH(4), .XLEN(32)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .busy      (busy),
    .rf_A3     (rf_A3),
    .rf_WD3    (rf_WD3),
    .rf_WE     (rf_WE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    vectors++; if (rf_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_we: got %b expected 0", rf_WE); end
    vectors++; if (rf_A3 !== 5'd0) begin miscompares++; $display("[TB] FAIL reset_a3: got %0d expected 0", rf_A3); end
    vectors++; if (rf_WD3 !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_wd3: got %h expected 0", rf_WD3); end
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_busy: got %h expected 0", busy); end
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", mem_ready); end
    reset = 1'b0;
    #1;
    vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release_ready: got %b expected 1", mem_ready); end
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    alu_valid = 1'b0;
    vectors++; if (rf_WE !== 1'b1) begin miscompares++; $display("[TB] FAIL alu_we: got %b expected 1", rf_WE); end
    vectors++; if (rf_A3 !== 5'd5) begin miscompares++; $display("[TB] FAIL alu_a3: got %0d expected 5", rf_A3); end
    vectors++; if (rf_WD3 !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL alu_wd3: got %h expected deadbeef", rf_WD3); end
    tick();
    vectors++; if (rf_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL alu_we_drop: got %b expected 0", rf_WE); end
    vectors++; if (rf_A3 !== 5'd5) begin miscompares++; $display("[TB] FAIL alu_a3_hold: got %0d expected 5", rf_A3); end
  endtask

  task automatic test_priority();
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0080) begin miscompares++; $display("[TB] FAIL prio_busy_set: got %h expected 00000080", busy); end
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h1234;
    alu_valid = 1'b1; alu_rd = 5'd3;
    for (int k = 0; k < 3; k++) begin
      alu_data = 32'h100 + k;
      tick();
      mem_valid = 1'b0;
      vectors++; if (rf_A3 !== 5'd3 || rf_WD3 !== 32'h100 + k || rf_WE !== 1'b1) begin miscompares++; $display("[TB] FAIL prio_alu%0d: got we=%b a3=%0d wd=%h expected we=1 a3=3 wd=%h", k, rf_WE, rf_A3, rf_WD3, 32'h100 + k); end
      vectors++; if (busy !== 32'h0000_0080) begin miscompares++; $display("[TB] FAIL prio_busy_hold%0d: got %h expected 00000080", k, busy); end
    end
    alu_valid = 1'b0;
    tick();
    vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'd7 || rf_WD3 !== 32'h1234) begin miscompares++; $display("[TB] FAIL prio_mem: got we=%b a3=%0d wd=%h expected we=1 a3=7 wd=00001234", rf_WE, rf_A3, rf_WD3); end
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("[TB] FAIL prio_busy_clr: got %h expected 0", busy); end
  endtask

  task automatic test_fill();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300;
    for (int k = 0; k < 4; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(10 + k); mem_data = 32'hA0 + k;
      vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready%0d: got %b expected 1", k, mem_ready); end
      tick();
    end
    mem_rd = 5'd14; mem_data = 32'hA4;
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full: got %b expected 0", mem_ready); end
    tick();
    vectors++; if (rf_A3 !== 5'd3) begin miscompares++; $display("[TB] FAIL fill_alu: got %0d expected 3", rf_A3); end
    alu_valid = 1'b0;
    vectors++; if (mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_full_pop: got %b expected 0", mem_ready); end
    tick();
    vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'd10 || rf_WD3 !== 32'hA0) begin miscompares++; $display("[TB] FAIL fill_commit0: got we=%b a3=%0d wd=%h expected we=1 a3=10 wd=000000a0", rf_WE, rf_A3, rf_WD3); end
    vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fill_ready_after_pop: got %b expected 1", mem_ready); end
    tick();
    mem_valid = 1'b0;
    for (int k = 1; k < 5; k++) begin
      vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'(10 + k) || rf_WD3 !== 32'hA0 + k) begin miscompares++; $display("[TB] FAIL fill_commit%0d: got we=%b a3=%0d wd=%h expected we=1 a3=%0d wd=%h", k, rf_WE, rf_A3, rf_WD3, 10 + k, 32'hA0 + k); end
      tick();
    end
    vectors++; if (rf_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_drained: got %b expected 0", rf_WE); end
  endtask

  task automatic test_zero();
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hFFFF_FFFF;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555_5555;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (rf_WE !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_we%0d: got %b expected 0", k, rf_WE); end
      tick();
    end
    vectors++; if (rf_A3 !== 5'd14 || rf_WD3 !== 32'hA4) begin miscompares++; $display("[TB] FAIL zero_hold: got a3=%0d wd=%h expected a3=14 wd=000000a4", rf_A3, rf_WD3); end
    vectors++; if (mem_ready !== 1'b1 || busy !== 32'h0) begin miscompares++; $display("[TB] FAIL zero_idle: got ready=%b busy=%h expected ready=1 busy=0", mem_ready, busy); end
  endtask

  task automatic test_set_wins();
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h333;
    iss_valid = 1'b0;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'd9 || rf_WD3 !== 32'h99) begin miscompares++; $display("[TB] FAIL setwin_commit: got we=%b a3=%0d wd=%h expected we=1 a3=9 wd=00000099", rf_WE, rf_A3, rf_WD3); end
    vectors++; if (busy !== 32'h0000_0200) begin miscompares++; $display("[TB] FAIL setwin_busy: got %h expected 00000200", busy); end
    mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9A;
    tick();
    mem_valid = 1'b0;
    tick();
    tick();
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("[TB] FAIL setwin_clear: got %h expected 0", busy); end
  endtask

  task automatic test_bypass();
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0010) begin miscompares++; $display("[TB] FAIL byp_busy_set: got %h expected 00000010", busy); end
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    tick();
    mem_valid = 1'b0;
`ifdef WB_MEM_BYPASS_EN
    vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'd4 || rf_WD3 !== 32'h44) begin miscompares++; $display("[TB] FAIL byp_lat1: got we=%b a3=%0d wd=%h expected we=1 a3=4 wd=00000044", rf_WE, rf_A3, rf_WD3); end
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("[TB] FAIL byp_busy_clr: got %h expected 0", busy); end
`else
    vectors++; if (rf_WE !== 1'b0 || busy !== 32'h0000_0010) begin miscompares++; $display("[TB] FAIL byp_lat1_none: got we=%b busy=%h expected we=0 busy=00000010", rf_WE, busy); end
    tick();
    vectors++; if (rf_WE !== 1'b1 || rf_A3 !== 5'd4 || rf_WD3 !== 32'h44) begin miscompares++; $display("[TB] FAIL byp_lat2: got we=%b a3=%0d wd=%h expected we=1 a3=4 wd=00000044", rf_WE, rf_A3, rf_WD3); end
    vectors++; if (busy !== 32'h0) begin miscompares++; $display("[TB] FAIL byp_busy_clr: got %h expected 0", busy); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1;
    iss_rd = 5'd1; tick();
    iss_rd = 5'd2; tick();
    iss_rd = 5'd8; tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h777;
    for (int k = 0; k < 3; k++) begin
      mem_valid = 1'b1; mem_rd = 5'(20 + k); mem_data = 32'hC0 + k;
      tick();
    end
    mem_valid = 1'b0;
    vectors++; if (busy !== 32'h0000_0106 || rf_WE !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_pre: got busy=%h we=%b expected busy=00000106 we=1", busy, rf_WE); end
    reset = 1'b1;
    #1;
    vectors++; if (rf_WE !== 1'b0 || busy !== 32'h0 || mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_async: got we=%b busy=%h ready=%b expected we=0 busy=0 ready=0", rf_WE, busy, mem_ready); end
    alu_valid = 1'b0;
    tick();
    vectors++; if (rf_WE !== 1'b0 || mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_held: got we=%b ready=%b expected we=0 ready=0", rf_WE, mem_ready); end
    reset = 1'b0;
    #1;
    vectors++; if (mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_ready: got %b expected 1", mem_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (rf_WE !== 1'b0 || busy !== 32'h0) begin miscompares++; $display("[TB] FAIL rmid_empty%0d: got we=%b busy=%h expected we=0 busy=0", k, rf_WE, busy); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
    iss_valid = 1'b0; iss_rd = 5'd0;
    test_reset();
    test_alu();
    test_priority();
    test_fill();
    test_zero();
    test_set_wins();
    test_bypass();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
